ahb_lite_arbiter: RTL and testbench
===================================

// Module: ahb_lite_arbiter
// PURPOSE
//  Shares one AHB-Lite bus between NUM_MASTERS controllers (AXI-to-AHB bridges, DMA) ahead of the AHB mux.
//  Arbitrates in the address phase and tracks the data-phase owner for HWDATA/HRESP routing.
//  Masters that lose arbitration are held off with hready low; they hold their address phase stable.
// PARAMETERS
//  NUM_MASTERS  2   number of requesting controllers (2..8)
//  ADDR_W       32  haddr width
//  DATA_W       32  hwdata/hrdata width
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               asynchronous, active-high reset
//  m_htrans   in   2*NUM_MASTERS   per-master htrans (IDLE=00, NONSEQ=10, SEQ=11)
//  m_haddr    in   ADDR_W*N        per-master haddr
//  m_hwrite   in   N               per-master hwrite
//  m_hsize    in   2*N             per-master hsize
//  m_hburst   in   3*N             per-master hburst
//  m_hwdata   in   DATA_W*N        per-master hwdata (data phase)
//  m_hready   out  N               per-master hready
//  m_hresp    out  N               per-master hresp
//  m_hrdata   out  DATA_W          read data, broadcast to all masters
//  haddr/hwrite/hsize/hburst/htrans/hwdata  out  (ADDR_W/1/2/3/2/DATA_W)  to AHB mux
//  hready     in   1               bus hready from mux
//  hresp      in   1               bus hresp from mux
//  hrdata     in   DATA_W          bus hrdata from mux
//  gnt        out  N               one-hot address-phase grant (debug/perf)
// BEHAVIOUR
//  - req[i] = m_htrans[i][1]. Grant is combinational; it updates only in cycles with hready=1 and is held while hready=0.
//  - Priority: the current data-phase owner, if it requests, wins (pipelined continuation).
//    Otherwise, round-robin starting at rr_ptr+1 mod N.
//  - rr_ptr <= granted index on each accepted address phase (hready=1 & any req). Reset value: 0.
//  - The bus address-phase outputs carry the granted master's signals.
//    With no request: htrans=IDLE, haddr=0, hwrite=0, hsize=2'b10, hburst=0, gnt=0.
//  - Data-phase tracking: on hready=1, d_valid <= any req, d_owner <= granted index. Reset: d_valid=0, d_owner=0.
//  - hwdata = m_hwdata[d_owner] when d_valid, else 0.
//  - m_hresp[i] = hresp & d_valid & (d_owner==i). m_hrdata = hrdata.
//  - m_hready[i] = hready & ~(req[i] & ~gnt[i]); a stalled requester sees 0 and must hold its address phase.
//    An idle master with no data phase sees the bus hready.
//  - Latency: zero added cycles for an uncontested transfer. A loser is granted on the first hready=1 cycle in which it wins round-robin.
//  - Error response: the two-cycle ERROR response (hresp=1, hready 0 then 1) is routed only to d_owner.
//    The grant is held during the first cycle of the response.
//  - Simultaneous requests from all masters with d_valid=0: the grant goes to the first index after rr_ptr. Back-to-back cycles rotate.
//  - Wrap-around: rr_ptr = N-1 -> the search restarts at index 0.
//  - Reset mid-transfer: all state clears asynchronously; outputs return to IDLE values immediately.
//    No in-flight data phase is completed.
//  - Bridges never request during their own data phase, so round-robin fairness holds.
//    A master that pipelines continuously can starve others (documented limitation).
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: round-robin is replaced by fixed priority, with lowest index highest.
//    Data-owner continuation still applies. rr_ptr is not instantiated.
//  ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING
//  1 Single master 0 reads 0x1000, slave hready=1: htrans=NONSEQ the same cycle, m_hready[0]=1, gnt=01, data returns next cycle.
//  2 Both request the same cycle after reset (rr_ptr=0): gnt=10, m_hready[0]=0.
//    Master 0 granted on the next hready=1 cycle; rr_ptr ends at 0.
//  3 Master 1 write 0xDEADBEEF to 0x2000 while master 0 is idle: hwdata=0xDEADBEEF in the data phase with d_owner=1.
//  4 Slave inserts 3 wait states during master 0's data phase while master 1 requests:
//    gnt and bus address are stable, and m_hready[1]=0 throughout.
//  5 Slave ERROR on master 1 read: m_hresp=2'b10 for 2 cycles, and m_hresp[0] stays 0.
//  6 rst asserted mid data phase: the bus goes to htrans=IDLE and gnt=0 that cycle, with d_valid=0.
//    Rerun scenario 2 with ARB_FIXED_PRIO_EN: master 0 always wins first.

Source files
------------

// File: rtl/ahb_lite_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_arbiter_if
//   Bundles the per-master AHB-Lite request/response signals and the shared
//   bus signals (towards the AHB mux) of ahb_lite_arbiter.
//
//   Per-master side (flattened, master i occupies slice i):
//     m_htrans  [2*N]       htrans (IDLE=00, NONSEQ=10, SEQ=11)
//     m_haddr   [ADDR_W*N]  address
//     m_hwrite  [N]         write strobe
//     m_hsize   [2*N]       transfer size
//     m_hburst  [3*N]       burst type
//     m_hwdata  [DATA_W*N]  write data (data phase)
//     m_hready  [N]         per-master ready (0 = stalled)
//     m_hresp   [N]         per-master response (data-phase owner only)
//     m_hrdata  [DATA_W]    read data broadcast to all masters
//   Bus side:
//     htrans/haddr/hwrite/hsize/hburst/hwdata  address/data phase to the mux
//     hready/hresp/hrdata                      response from the mux
//     gnt [N]                                  one-hot address-phase grant
//
//   Modports:
//     slave  - arbiter view (consumes master requests and bus responses)
//     master - environment view (masters plus AHB mux)
// ---------------------------------------------------------------------------
interface ahb_lite_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  logic [2*NUM_MASTERS-1:0]      m_htrans;
  logic [ADDR_W*NUM_MASTERS-1:0] m_haddr;
  logic [NUM_MASTERS-1:0]        m_hwrite;
  logic [2*NUM_MASTERS-1:0]      m_hsize;
  logic [3*NUM_MASTERS-1:0]      m_hburst;
  logic [DATA_W*NUM_MASTERS-1:0] m_hwdata;
  logic [NUM_MASTERS-1:0]        m_hready;
  logic [NUM_MASTERS-1:0]        m_hresp;
  logic [DATA_W-1:0]             m_hrdata;

  logic [1:0]                    htrans;
  logic [ADDR_W-1:0]             haddr;
  logic                          hwrite;
  logic [1:0]                    hsize;
  logic [2:0]                    hburst;
  logic [DATA_W-1:0]             hwdata;
  logic                          hready;
  logic                          hresp;
  logic [DATA_W-1:0]             hrdata;
  logic [NUM_MASTERS-1:0]        gnt;

  modport slave (
    input  m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hwdata,
    input  hready, hresp, hrdata,
    output m_hready, m_hresp, m_hrdata,
    output htrans, haddr, hwrite, hsize, hburst, hwdata, gnt
  );

  modport master (
    output m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hwdata,
    output hready, hresp, hrdata,
    input  m_hready, m_hresp, m_hrdata,
    input  htrans, haddr, hwrite, hsize, hburst, hwdata, gnt
  );
endinterface

// File: rtl/ahb_lite_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_lite_arbiter
//   Shares one AHB-Lite bus between NUM_MASTERS controllers. Arbitration is
//   done in the address phase (combinational grant, held while the bus
//   stalls); the data-phase owner is tracked for HWDATA and HRESP routing.
//   Losing masters see m_hready low and hold their address phase.
//
//   Priority: the current data-phase owner, if it requests again, keeps the
//   bus (pipelined continuation). Otherwise round-robin starting after the
//   last granted master. A master that pipelines continuously can starve
//   the others.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset; clears state and forces the
//            bus address phase to IDLE immediately
//     bus  - ahb_lite_arbiter_if.slave (per-master and shared bus signals)
//
//   Build option:
//     ARB_FIXED_PRIO_EN - when defined, round-robin is replaced by fixed
//                         priority (lowest index wins); no rr pointer exists.
// ---------------------------------------------------------------------------
module ahb_lite_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  ahb_lite_arbiter_if.slave   bus
);

  localparam int         IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HSIZE_WORD  = 2'b10;

  logic [NUM_MASTERS-1:0] req;
  logic                   any_req;
  logic [IDX_W-1:0]       arb_idx;    // winner of this cycle's arbitration
  logic                   sel_valid;  // bus address phase driven by a master
  logic [IDX_W-1:0]       sel_idx;    // master driving the bus address phase
  logic [NUM_MASTERS-1:0] gnt;
  logic                   d_valid;    // a data phase is in flight
  logic [IDX_W-1:0]       d_owner;    // master owning that data phase
  int                     sel_i;
  int                     own_i;

`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]       rr_ptr;     // last master granted an address phase
`endif

  // NOTE: combinational blocks use blocking '=' with every output given a
  // default first, so no latches are inferred; registers below use '<='.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req[i] = bus.m_htrans[2*i+1];
    end
  end

  assign any_req = |req;

  // Arbitration. Candidates are scanned from lowest to highest priority so
  // the last match wins, which avoids an early exit from the loop.
  always_comb begin
    int cand;
    arb_idx = '0;
    cand    = 0;
    if (d_valid && req[d_owner]) begin
      arb_idx = d_owner;
    end else begin
`ifdef ARB_FIXED_PRIO_EN
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[i]) arb_idx = IDX_W'(i);
      end
`else
      // Offset NUM_MASTERS lands back on rr_ptr (lowest priority); offset 1
      // is the master right after it (highest priority), wrapping to 0.
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
        if (req[cand]) arb_idx = IDX_W'(cand);
      end
`endif
    end
  end

  // While the bus stalls the grant must not move. The grant captured on the
  // last hready=1 cycle is exactly the data-phase owner, so d_valid/d_owner
  // double as the held grant. Reset forces the address phase idle at once.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (!rst) begin
      if (bus.hready) begin
        sel_valid = any_req;
        sel_idx   = arb_idx;
      end else begin
        sel_valid = d_valid;
        sel_idx   = d_owner;
      end
    end
  end

  assign sel_i = int'(sel_idx);
  assign own_i = int'(d_owner);

  always_comb begin
    gnt        = '0;
    bus.htrans = HTRANS_IDLE;
    bus.haddr  = '0;
    bus.hwrite = 1'b0;
    bus.hsize  = HSIZE_WORD;
    bus.hburst = '0;
    if (sel_valid) begin
      gnt[sel_idx] = 1'b1;
      bus.htrans   = bus.m_htrans[2*sel_i +: 2];
      bus.haddr    = bus.m_haddr[ADDR_W*sel_i +: ADDR_W];
      bus.hwrite   = bus.m_hwrite[sel_idx];
      bus.hsize    = bus.m_hsize[2*sel_i +: 2];
      bus.hburst   = bus.m_hburst[3*sel_i +: 3];
    end
  end

  assign bus.gnt = gnt;

  // A requester that is not granted is stalled; everyone else follows the
  // bus hready. Responses go only to the data-phase owner.
  always_comb begin
    bus.m_hready = '0;
    bus.m_hresp  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.m_hready[i] = bus.hready & ~(req[i] & ~gnt[i]);
      bus.m_hresp[i]  = bus.hresp & d_valid & (own_i == i);
    end
  end

  assign bus.hwdata   = d_valid ? bus.m_hwdata[DATA_W*own_i +: DATA_W] : '0;
  assign bus.m_hrdata = bus.hrdata;

  // NOTE: every state register has an explicit reset value; an in-flight
  // data phase is simply dropped when rst asserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_owner <= '0;
    end else if (bus.hready) begin
      d_valid <= any_req;
      d_owner <= arb_idx;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (bus.hready && any_req) begin
      rr_ptr <= arb_idx;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_arbiter
//   Directed bench for ahb_lite_arbiter with two masters. Master 0 reads
//   0x1000 (hwdata 0x11111111), master 1 writes 0xDEADBEEF to 0x2000.
//   A table of single-cycle vectors covers the main arbitration paths; hand
//   sequences cover wait states, the two-cycle ERROR response and reset in
//   the middle of a data phase. Inputs change 1 ns after the rising edge and
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_lite_arbiter;

  localparam int N      = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'hDEAD_BEEF;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  ahb_lite_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_lite_arbiter #(.NUM_MASTERS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t0;        // master 0 htrans
    logic [1:0]  t1;        // master 1 htrans
    logic [1:0]  e_gnt;
    logic [1:0]  e_htrans;
    logic [31:0] e_haddr;
    logic [1:0]  e_mready;  // {m_hready[1], m_hready[0]}
    logic [31:0] e_hwdata;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t0, input logic [1:0] t1,
                       input logic rdy, input logic resp);
    bus.m_htrans = {t1, t0};
    bus.hready   = rdy;
    bus.hresp    = resp;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Static master attributes.
    bus.m_haddr  = {A1, A0};
    bus.m_hwrite = 2'b10;
    bus.m_hsize  = {2'b10, 2'b10};
    bus.m_hburst = {3'b000, 3'b001};
    bus.m_hwdata = {W1, W0};
    bus.hrdata   = 32'hCAFE_0042;
    drive(2'b00, 2'b00, 1'b1, 1'b0);

    //           t0     t1     gnt    htrans haddr mready hwdata
    vecs[0]  = '{2'b10, 2'b00, 2'b01, 2'b10, A0,   2'b11, 32'h0}; // single master 0
    vecs[1]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 2'b11, W0};   // its data phase
    vecs[2]  = '{2'b10, 2'b10, 2'b10, 2'b10, A1,   2'b10, 32'h0}; // both, rr_ptr=0 -> m1
    vecs[3]  = '{2'b10, 2'b00, 2'b01, 2'b10, A0,   2'b11, W1};    // held m0 now wins
    vecs[4]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 2'b11, W0};
    vecs[5]  = '{2'b00, 2'b10, 2'b10, 2'b10, A1,   2'b11, 32'h0}; // m1 write alone
    vecs[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 2'b11, W1};
    vecs[7]  = '{2'b10, 2'b10, 2'b01, 2'b10, A0,   2'b01, 32'h0}; // rr_ptr=1 wraps to 0
    vecs[8]  = '{2'b00, 2'b10, 2'b10, 2'b10, A1,   2'b11, W0};    // rotates to m1
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 2'b11, W1};
    vecs[10] = '{2'b10, 2'b00, 2'b01, 2'b10, A0,   2'b11, 32'h0};
    vecs[11] = '{2'b11, 2'b10, 2'b01, 2'b11, A0,   2'b01, W0};    // owner continuation
    vecs[12] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 2'b11, W0};

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst gnt",    bus.gnt,    2'b00);
    check("rst htrans", bus.htrans, 2'b00);
    check("rst haddr",  bus.haddr,  32'h0);
    check("rst hsize",  bus.hsize,  2'b10);
    check("rst hwdata", bus.hwdata, 32'h0);
    check("rst hresp",  bus.m_hresp, 2'b00);
    rst = 1'b0;

`ifndef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      drive(vecs[i].t0, vecs[i].t1, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d gnt", i),      bus.gnt,      vecs[i].e_gnt);
      check($sformatf("v%0d htrans", i),   bus.htrans,   vecs[i].e_htrans);
      check($sformatf("v%0d haddr", i),    bus.haddr,    vecs[i].e_haddr);
      check($sformatf("v%0d m_hready", i), bus.m_hready, vecs[i].e_mready);
      check($sformatf("v%0d hwdata", i),   bus.hwdata,   vecs[i].e_hwdata);
      check($sformatf("v%0d hwrite", i),   bus.hwrite,   (vecs[i].e_gnt == 2'b10));
    end
`endif
    check("m_hrdata", bus.m_hrdata, 32'hCAFE_0042);

    // Three wait states in master 0's data phase while master 1 requests.
    next_cycle();
    drive(2'b10, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    check("ws addr gnt", bus.gnt, 2'b01);
    for (int w = 0; w < 3; w++) begin
      next_cycle();
      drive(2'b00, 2'b10, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("ws%0d gnt", w),      bus.gnt,      2'b01);
      check($sformatf("ws%0d haddr", w),    bus.haddr,    A0);
      check($sformatf("ws%0d m_hready", w), bus.m_hready, 2'b00);
    end
    next_cycle();
    drive(2'b00, 2'b10, 1'b1, 1'b0);
    @(negedge clk);
    check("ws end gnt",      bus.gnt,      2'b10);
    check("ws end haddr",    bus.haddr,    A1);
    check("ws end m_hready", bus.m_hready, 2'b11);
    check("ws end hwdata",   bus.hwdata,   W0);
    next_cycle();
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    check("ws data hwdata", bus.hwdata, W1);

    // Two-cycle ERROR on a master 1 read.
    bus.m_hwrite = 2'b00;
    next_cycle();
    drive(2'b00, 2'b10, 1'b1, 1'b0);
    @(negedge clk);
    check("err addr gnt", bus.gnt, 2'b10);
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    check("err c1 m_hresp", bus.m_hresp, 2'b10);
    check("err c1 gnt",     bus.gnt,     2'b10);
    next_cycle();
    drive(2'b00, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    check("err c2 m_hresp", bus.m_hresp, 2'b10);
    next_cycle();
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    check("err done m_hresp", bus.m_hresp, 2'b00);
    bus.m_hwrite = 2'b10;

    // Reset in the middle of master 0's data phase, then both request.
    next_cycle();
    drive(2'b10, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    check("mrst addr gnt", bus.gnt, 2'b01);
    next_cycle();
    drive(2'b10, 2'b10, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check("mrst gnt",     bus.gnt,     2'b00);
    check("mrst htrans",  bus.htrans,  2'b00);
    check("mrst hwdata",  bus.hwdata,  32'h0);
    check("mrst m_hresp", bus.m_hresp, 2'b00);
    #1;
    rst = 1'b0;
    bus.hresp = 1'b0;
    @(negedge clk);
`ifdef ARB_FIXED_PRIO_EN
    check("post rst gnt", bus.gnt,      2'b01);
    check("post rst rdy", bus.m_hready, 2'b01);
    next_cycle();
    drive(2'b00, 2'b10, 1'b1, 1'b0);
    @(negedge clk);
    check("post rst next gnt", bus.gnt, 2'b10);
`else
    check("post rst gnt", bus.gnt,      2'b10);
    check("post rst rdy", bus.m_hready, 2'b10);
    next_cycle();
    drive(2'b10, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    check("post rst next gnt", bus.gnt, 2'b01);
`endif
    next_cycle();
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    check("final idle gnt", bus.gnt, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
